regfile_sb: RTL and testbench

Parametrised multi-port register file with a write-back scoreboard, for the pipelined core's ID stage. It replaces the fixed 32×32, two-read-port register file. It adds:
- a configurable number of read ports;
- per-register pending tracking, so the hazard unit can stall on RAW/WAW hazards;
- optional write-to-read bypass.

Register 0 is hardwired to zero.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 74 +++++++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file geometry defaults, the zero-register
// index and the pend_cnt step helper used by the scoreboard.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A rising and a falling pending bit in the same cycle cancel out.
  function automatic cnt_op_e cnt_step(input logic rise, input logic fall);
    case ({rise, fall})
      2'b10:   return CNT_INC;
      2'b01:   return CNT_DEC;
      default: return CNT_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits, pend_cnt and issue acceptance for regfile_sb.
// REGFILE_BYPASS_EN also accepts an issue whose target is written back this cycle.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ready,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [2**ADDR_W-1:0] pending_q;
  logic [2**ADDR_W-1:0] pending_d;
  logic [ADDR_W:0]      pend_cnt_q;
  logic                 wb_hit;
  logic                 iss_nz;
  logic                 wb_byp;
  logic                 do_set;
  logic                 rise;
  logic                 fall;

  assign wb_hit = we && (waddr != ZERO_IDX);
  assign iss_nz = iss_addr != ZERO_IDX;

`ifdef REGFILE_BYPASS_EN
  assign wb_byp = wb_hit && (waddr == iss_addr);
`else
  assign wb_byp = 1'b0;
`endif

  // No path from iss_valid into iss_ready.
  assign iss_ready = !iss_nz || !pending_q[iss_addr] || wb_byp;
  assign do_set    = iss_valid && iss_ready && iss_nz;

  // Set is applied after clear so that a coinciding issue wins.
  always_comb begin
    // NOTE: every always_comb target gets a default first, otherwise a latch is inferred.
    pending_d = pending_q;
    if (wb_hit) pending_d[waddr] = 1'b0;
    if (do_set) pending_d[iss_addr] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
  end

  assign rise = do_set && !pending_q[iss_addr];
  assign fall = wb_hit && pending_q[waddr] && !(do_set && (iss_addr == waddr));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      case (cnt_step(rise, fall))
        CNT_INC: pend_cnt_q <= pend_cnt_q + 1'b1;
        CNT_DEC: pend_cnt_q <= pend_cnt_q - 1'b1;
        default: pend_cnt_q <= pend_cnt_q;
      endcase
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-back scoreboard; register 0 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards the current write-back onto matching read ports.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wb_hit;

  assign wb_hit = we && (waddr != ZERO_IDX);

  // NOTE: the array sits on the async reset because a mid-run reset must clear every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wb_hit) begin
      mem[waddr] <= wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .pending   (pending),
    .pend_cnt  (pend_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rp;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      rp = 1'b0;
      if (ra != ZERO_IDX) begin
        rd = mem[ra];
        rp = pending[ra];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (waddr == ra)) begin
          rd = wdata;
          rp = 1'b0;
        end
`endif
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
    assign rpend[i]                  = rp;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters: 32x32, two read ports).
// Expected values depend on whether REGFILE_BYPASS_EN is defined for the build.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rpend;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic [ADDR_W:0]          pend_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int base;

  regfile_sb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rpend     (rpend),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after a rising edge; inputs change here and are checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
    #3;
    check("reset_rdata",     96'(rdata),     96'(0));
    check("reset_rpend",     96'(rpend),     96'(0));
    check("reset_pend_cnt",  96'(pend_cnt),  96'(0));
    check("reset_iss_ready", 96'(iss_ready), 96'(1));
    #9 rst_n = 1'b1;

    // Every index on both ports reads zero and not pending.
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      check($sformatf("reset_read_%0d", a), 96'({rdata, rpend}), 96'(0));
    end

    // Write r5, read it back next cycle.
    tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    #1;
    check("r5_same_cycle", 96'(rdata[31:0]), BYP ? 96'h0DEADBEEF : 96'h0);
    tick();
    we = 1'b0;
    #1;
    check("r5_readback", 96'(rdata[31:0]), 96'hDEADBEEF);

    // Write to r0 is discarded, bypass never applies to r0.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd0, 5'd5};
    #1;
    check("r0_during_write", 96'(rdata[63:32]), 96'h0);
    tick();
    we = 1'b0;
    #1;
    check("r0_after_write", 96'(rdata[63:32]), 96'h0);
    check("r5_held",        96'(rdata[31:0]),  96'hDEADBEEF);

    // Issue r7, then write it back.
    iss_valid = 1'b1; iss_addr = 5'd7;
    #1;
    check("iss7_ready", 96'(iss_ready), 96'(1));
    tick();
    iss_valid = 1'b0; raddr = {5'd7, 5'd5};
    #1;
    check("r7_rpend",       96'(rpend),     96'(2'b10));
    check("r7_pend_cnt",    96'(pend_cnt),  96'(1));
    check("r7_iss_blocked", 96'(iss_ready), 96'(0));
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5;
    #1;
    check("r7_wb_rpend",     96'(rpend),          BYP ? 96'(2'b00) : 96'(2'b10));
    check("r7_wb_rdata",     96'(rdata[63:32]),   BYP ? 96'hA5 : 96'h0);
    check("r7_wb_iss_ready", 96'(iss_ready),      BYP ? 96'(1) : 96'(0));
    tick();
    we = 1'b0;
    #1;
    check("r7_cleared_rpend", 96'(rpend),        96'(0));
    check("r7_cleared_cnt",   96'(pend_cnt),     96'(0));
    check("r7_readback",      96'(rdata[63:32]), 96'hA5);

    // Make r9 pending, then write it back while issuing r9 again.
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0; raddr = {5'd9, 5'd0};
    #1;
    check("r9_pend_cnt", 96'(pend_cnt), 96'(1));
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    check("r9_coincide_ready", 96'(iss_ready), BYP ? 96'(1) : 96'(0));
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    // Accepted (bypass): set wins and count holds; otherwise the clear alone lands.
    check("r9_coincide_rpend", 96'(rpend),    BYP ? 96'(2'b10) : 96'(2'b00));
    check("r9_coincide_cnt",   96'(pend_cnt), BYP ? 96'(1) : 96'(0));
    base = BYP ? 1 : 0;

    // Set wins on a non-pending register written back in the same cycle.
    we = 1'b1; waddr = 5'd10; wdata = 32'h10; iss_valid = 1'b1; iss_addr = 5'd10;
    raddr = {5'd10, 5'd11};
    #1;
    check("r10_ready", 96'(iss_ready), 96'(1));
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("r10_rpend", 96'(rpend),    96'(2'b10));
    check("r10_cnt",   96'(pend_cnt), 96'(base + 1));

    // Set r11 while clearing r10: count unchanged.
    we = 1'b1; waddr = 5'd10; wdata = 32'h1010; iss_valid = 1'b1; iss_addr = 5'd11;
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("swap_rpend", 96'(rpend),    96'(2'b01));
    check("swap_cnt",   96'(pend_cnt), 96'(base + 1));

    // Write-back to a non-pending register: data lands, count unchanged.
    we = 1'b1; waddr = 5'd12; wdata = 32'hC0FFEE; raddr = {5'd12, 5'd12};
    tick();
    we = 1'b0;
    #1;
    check("r12_both_ports", 96'(rdata), 96'({32'hC0FFEE, 32'hC0FFEE}));
    check("r12_rpend",      96'(rpend), 96'(0));
    check("r12_cnt",        96'(pend_cnt), 96'(base + 1));

    // Write 0x55 to r3 while port 1 reads it.
    we = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr = {5'd3, 5'd5};
    #1;
    check("byp_r3_rdata", 96'(rdata[63:32]), BYP ? 96'h55 : 96'h0);
    check("byp_r3_rpend", 96'(rpend[1]),     96'(0));
    check("byp_r5_port0", 96'(rdata[31:0]),  96'hDEADBEEF);
    tick();
    we = 1'b0;

    // Issue r1, r2, r3 on consecutive cycles, then reset between edges.
    iss_valid = 1'b1; iss_addr = 5'd1;
    tick();
    iss_addr = 5'd2;
    tick();
    iss_addr = 5'd3;
    tick();
    iss_valid = 1'b0; raddr = {5'd2, 5'd1};
    #1;
    check("pre_rst_cnt",   96'(pend_cnt), 96'(base + 4));
    check("pre_rst_rpend", 96'(rpend),    96'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cnt",   96'(pend_cnt),  96'(0));
    check("mid_rst_rpend", 96'(rpend),     96'(0));
    check("mid_rst_ready", 96'(iss_ready), 96'(1));
    raddr = {5'd3, 5'd5};
    #1;
    check("mid_rst_rdata", 96'(rdata), 96'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
